// File: rtl/mux4x1_serial.sv
// mux4x1_serial
//
// Purpose:
//   Transmit-side 4:1 byte serializer. Four parallel byte lanes, updated at
//   the slow (1f) rate, are merged into a single byte stream at the fast (4f)
//   rate. A free-running 2-bit phase counter on clk4f takes the place of the
//   separate 1f/2f clock edges.
//
//   The frame is built around the phase-0 edge:
//     - Lanes 1..3 and their valid bits are captured into hold registers.
//     - Lane 0 is emitted straight from in0/valid_in[0] (bypass).
//   On the following edges (phase 1..3), lanes 1..3 are emitted from the hold
//   registers. As a result, changes to the inputs during phases 1..3 cannot
//   leak into the frame currently being sent.
//
// Ports:
//   clk4f       in   1   fast clock; all logic runs on its rising edge
//   reset       in   1   synchronous, active-high reset
//   in0..in3    in   BW  lane data; sampled at phase 0 only
//   valid_in    in   4   per-lane valid (bit k qualifies in<k>); phase 0 only
//   out         out  BW  serialized byte (holds its value on invalid slots)
//   valid_out   out  1   out carries valid lane data this cycle
//   lane_id     out  2   lane index of the slot currently on out
//   frame_start out  1   one-cycle pulse coincident with the lane-0 slot
//   phase       out  2   current phase counter value
//
// All outputs are registered; there is no combinational input-to-output path.

module mux4x1_serial #(
  parameter int BW = 8
) (
  input  logic          clk4f,
  input  logic          reset,
  input  logic [BW-1:0] in0,
  input  logic [BW-1:0] in1,
  input  logic [BW-1:0] in2,
  input  logic [BW-1:0] in3,
  input  logic [3:0]    valid_in,
  output logic [BW-1:0] out,
  output logic          valid_out,
  output logic [1:0]    lane_id,
  output logic          frame_start,
  output logic [1:0]    phase
);

  // Hold registers for lanes 1..3 of the frame currently being emitted.
  logic [BW-1:0] h1, h2, h3;
  logic [3:1]    vh;

  // Data/valid of the slot that the next edge will emit. Lane 0 bypasses the
  // hold registers, which is what gives it its single-cycle latency.
  logic [BW-1:0] slot_data;
  logic          slot_valid;

  always_comb begin
    slot_data  = in0;
    slot_valid = valid_in[0];
    case (phase)
      2'd1: begin
        slot_data  = h1;
        slot_valid = vh[1];
      end
      2'd2: begin
        slot_data  = h2;
        slot_valid = vh[2];
      end
      2'd3: begin
        slot_data  = h3;
        slot_valid = vh[3];
      end
      default: begin
        slot_data  = in0;
        slot_valid = valid_in[0];
      end
    endcase
  end

  // Clearing vh on reset guarantees that stale hold contents from an
  // interrupted frame can never be flagged valid.
  always_ff @(posedge clk4f) begin
    if (reset) begin
      phase       <= 2'd0;
      out         <= '0;
      valid_out   <= 1'b0;
      lane_id     <= 2'd0;
      frame_start <= 1'b0;
      h1          <= '0;
      h2          <= '0;
      h3          <= '0;
      vh          <= 3'b000;
    end else begin
      // The 2-bit counter wraps 3->0 on its own.
      phase       <= phase + 2'd1;
      lane_id     <= phase;
      frame_start <= (phase == 2'd0);

      if (phase == 2'd0) begin
        h1 <= in1;
        h2 <= in2;
        h3 <= in3;
        vh <= valid_in[3:1];
      end

      // An invalid slot freezes out and only drops valid_out.
      valid_out <= slot_valid;
      if (slot_valid) begin
        out <= slot_data;
      end
    end
  end

endmodule

// File: tb/tb_mux4x1_serial.sv
// tb_mux4x1_serial
//
// Purpose:
//   Directed, self-checking bench for mux4x1_serial. Each scenario task
//   drives its own stimulus and compares the registered outputs against
//   hand-computed values. The loopback task reassembles lanes from the serial
//   stream by lane_id, in the way a downstream 1x4 demux would.
//
// Timing:
//   - Inputs are driven, and outputs sampled, 1 time unit after each rising
//     edge of clk4f.
//   - Every scenario task begins and ends with phase == 0, so the next edge is
//     always a capture edge.

module tb_mux4x1_serial;

  localparam int BW = 8;

  logic          clk4f;
  logic          reset;
  logic [BW-1:0] in0, in1, in2, in3;
  logic [3:0]    valid_in;
  logic [BW-1:0] out;
  logic          valid_out;
  logic [1:0]    lane_id;
  logic          frame_start;
  logic [1:0]    phase;

  int checks;
  int errors;

  mux4x1_serial #(.BW(BW)) dut (
    .clk4f       (clk4f),
    .reset       (reset),
    .in0         (in0),
    .in1         (in1),
    .in2         (in2),
    .in3         (in3),
    .valid_in    (valid_in),
    .out         (out),
    .valid_out   (valid_out),
    .lane_id     (lane_id),
    .frame_start (frame_start),
    .phase       (phase)
  );

  initial clk4f = 1'b0;
  always #5 clk4f = ~clk4f;

  // Safety net: the bench itself never waits on DUT events, but guard anyway.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach the summary, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk4f);
    #1;
  endtask

  task automatic set_lanes(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3,
                           input logic [3:0] v);
    in0      = d0;
    in1      = d1;
    in2      = d2;
    in3      = d3;
    valid_in = v;
  endtask

  // Reset held 3 cycles, then one fully valid frame FF/EE/DD/CC.
  task automatic test_reset;
    logic [7:0] exp_data [4];
    exp_data[0] = 8'hFF; exp_data[1] = 8'hEE; exp_data[2] = 8'hDD; exp_data[3] = 8'hCC;
    reset = 1'b1;
    set_lanes(8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if ({out, valid_out, lane_id, frame_start, phase} !== {8'h00, 1'b0, 2'd0, 1'b0, 2'd0}) begin
      errors++;
      $display("[TB] FAIL reset_state: actual out=%h v=%b lane=%0d fs=%b ph=%0d required out=00 v=0 lane=0 fs=0 ph=0",
               out, valid_out, lane_id, frame_start, phase);
    end
    set_lanes(8'hFF, 8'hEE, 8'hDD, 8'hCC, 4'hF);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({out, valid_out, lane_id, frame_start, phase} !==
          {exp_data[k], 1'b1, 2'(k), (k == 0), 2'(k + 1)}) begin
        errors++;
        $display("[TB] FAIL first_frame slot %0d: actual out=%h v=%b lane=%0d fs=%b ph=%0d required out=%h v=1 lane=%0d fs=%b ph=%0d",
                 k, out, valid_out, lane_id, frame_start, phase, exp_data[k], k, (k == 0), (k + 1) % 4);
      end
    end
  endtask

  // valid_in=1010 after a frame ending in CC: invalid slots freeze out.
  task automatic test_partial_valid;
    logic [7:0] exp_data [4];
    logic [3:0] exp_v;
    exp_data[0] = 8'hCC; exp_data[1] = 8'h22; exp_data[2] = 8'h22; exp_data[3] = 8'h44;
    exp_v = 4'b1010;
    set_lanes(8'h11, 8'h22, 8'h33, 8'h44, 4'b1010);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({out, valid_out, lane_id, frame_start} !== {exp_data[k], exp_v[k], 2'(k), (k == 0)}) begin
        errors++;
        $display("[TB] FAIL partial_valid slot %0d: actual out=%h v=%b lane=%0d fs=%b required out=%h v=%b lane=%0d fs=%b",
                 k, out, valid_out, lane_id, frame_start, exp_data[k], exp_v[k], k, (k == 0));
      end
    end
  endtask

  // in1 changes to 99 at phase 2: the current frame keeps 22, the next takes 99.
  task automatic test_hold_isolation;
    logic [7:0] exp_data [8];
    exp_data[0] = 8'h55; exp_data[1] = 8'h22; exp_data[2] = 8'h66; exp_data[3] = 8'h77;
    exp_data[4] = 8'h55; exp_data[5] = 8'h99; exp_data[6] = 8'h66; exp_data[7] = 8'h77;
    set_lanes(8'h55, 8'h22, 8'h66, 8'h77, 4'hF);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 1) in1 = 8'h99;
      // Once the second frame is captured, scramble the inputs; they must not leak.
      if (k == 4) set_lanes(8'hA5, 8'hA5, 8'hA5, 8'hA5, 4'h0);
      checks++;
      if ({out, valid_out, lane_id} !== {exp_data[k], 1'b1, 2'(k % 4)}) begin
        errors++;
        $display("[TB] FAIL hold_isolation slot %0d: actual out=%h v=%b lane=%0d required out=%h v=1 lane=%0d",
                 k, out, valid_out, lane_id, exp_data[k], k % 4);
      end
    end
  endtask

  // Two all-invalid frames: out frozen at 77, lane_id cycles, frame_start pulses twice.
  task automatic test_all_invalid;
    set_lanes(8'h12, 8'h34, 8'h56, 8'h78, 4'h0);
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({out, valid_out, lane_id, frame_start} !== {8'h77, 1'b0, 2'(k % 4), (k % 4 == 0)}) begin
        errors++;
        $display("[TB] FAIL all_invalid slot %0d: actual out=%h v=%b lane=%0d fs=%b required out=77 v=0 lane=%0d fs=%b",
                 k, out, valid_out, lane_id, frame_start, k % 4, (k % 4 == 0));
      end
    end
  endtask

  // Reset asserted at phase 2 of an A0..A3 frame; the A2/A3 bytes must never appear.
  task automatic test_reset_mid_frame;
    set_lanes(8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'hF);
    tick();
    tick();
    checks++;
    if ({out, valid_out, phase} !== {8'hA1, 1'b1, 2'd2}) begin
      errors++;
      $display("[TB] FAIL pre_reset: actual out=%h v=%b ph=%0d required out=a1 v=1 ph=2", out, valid_out, phase);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({out, valid_out, lane_id, frame_start, phase} !== {8'h00, 1'b0, 2'd0, 1'b0, 2'd0}) begin
      errors++;
      $display("[TB] FAIL mid_reset: actual out=%h v=%b lane=%0d fs=%b ph=%0d required out=00 v=0 lane=0 fs=0 ph=0",
               out, valid_out, lane_id, frame_start, phase);
    end
    reset = 1'b0;
    set_lanes(8'hB0, 8'hB1, 8'hB2, 8'hB3, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({out, valid_out, lane_id, frame_start} !== {8'hB0, (k == 0), 2'(k), (k == 0)}) begin
        errors++;
        $display("[TB] FAIL after_reset slot %0d: actual out=%h v=%b lane=%0d fs=%b required out=b0 v=%b lane=%0d fs=%b",
                 k, out, valid_out, lane_id, frame_start, (k == 0), k, (k == 0));
      end
    end
  endtask

  // 20 back-to-back frames of random data/valid, reassembled by lane_id and
  // compared frame by frame against the originals.
  task automatic test_back_to_back;
    logic [7:0] tx_data [4];
    logic [3:0] tx_valid;
    logic [7:0] rx_data [4];
    logic [3:0] rx_valid;
    logic [7:0] last_out;
    last_out = 8'hB0;
    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < 4; k++) tx_data[k] = 8'($urandom_range(0, 255));
      tx_valid = 4'($urandom_range(0, 15));
      set_lanes(tx_data[0], tx_data[1], tx_data[2], tx_data[3], tx_valid);
      rx_valid = 4'h0;
      for (int k = 0; k < 4; k++) begin
        rx_data[k] = 8'h00;
      end
      for (int k = 0; k < 4; k++) begin
        tick();
        // Garbage during phases 1..3 must not affect the frame in flight.
        set_lanes(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  4'($urandom_range(0, 15)));
        if (tx_valid[k]) last_out = tx_data[k];
        checks++;
        if ({out, lane_id, frame_start} !== {last_out, 2'(k), (k == 0)}) begin
          errors++;
          $display("[TB] FAIL loop_slot f%0d s%0d: actual out=%h lane=%0d fs=%b required out=%h lane=%0d fs=%b",
                   f, k, out, lane_id, frame_start, last_out, k, (k == 0));
        end
        rx_valid[lane_id] = valid_out;
        if (valid_out) rx_data[lane_id] = out;
      end
      checks++;
      if (rx_valid !== tx_valid) begin
        errors++;
        $display("[TB] FAIL loop_valid f%0d: actual valid=%b required valid=%b", f, rx_valid, tx_valid);
      end
      for (int k = 0; k < 4; k++) begin
        if (tx_valid[k]) begin
          checks++;
          if (rx_data[k] !== tx_data[k]) begin
            errors++;
            $display("[TB] FAIL loop_data f%0d lane%0d: actual %h required %h", f, k, rx_data[k], tx_data[k]);
          end
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    set_lanes(8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    test_reset();
    test_partial_valid();
    test_hold_isolation();
    test_all_invalid();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
